// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path.
//   DATA_W  : default sample width of one FIR output lane
//   N_LANES : number of lanes produced per clock by the unfolded FIR
//   lane_e  : lane-sequencing state used by the output serializer
package fir_pkg;

  localparam int DATA_W  = 10;
  localparam int N_LANES = 3;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_e;

  // Successor of a lane state; the unused encoding falls back to LANE0.
  function automatic lane_e next_lane(input lane_e cur);
    lane_e nxt;
    case (cur)
      LANE0:   nxt = LANE1;
      LANE1:   nxt = LANE2;
      LANE2:   nxt = LANE0;
      default: nxt = LANE0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/triplet_fifo.sv
// Triplet FIFO for the FIR output serializer.
// Stores whole {lane0,lane1,lane2} words and keeps the head entry in a
// register so the consumer sees it without a read-address mux on its path.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full unless popping)
//   pop        : drop the head entry (ignored when empty)
//   head       : registered copy of the head entry
//   full/empty : occupancy flags
//   count      : number of stored triplets, 0..DEPTH
module triplet_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_inc;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
  assign rptr_inc = rptr + AW'(1);

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers, occupancy count and registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Next head: the following stored entry, or the incoming word when
      // it will be the only one left (empty, or last entry leaving).
      if (do_pop) begin
        if (count > CW'(1)) begin
          head <= mem[rptr_inc];
        end else if (do_push) begin
          head <= din;
        end
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/fir_out_serializer.sv
// Serializes the three parallel lanes of an unfolded FIR into one sample
// stream with valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   din0..din2        : lane samples, lane 0 oldest
//   vin0..vin2        : per-lane valids; all three must agree
//   rdy               : downstream ready
//   dout, vout        : serialized sample and its valid
//   ovf               : sticky, a valid triplet was dropped on a full FIFO
//   lane_err          : sticky, lane valids disagreed in some cycle
module fir_out_serializer #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic              vin0,
  input  logic              vin1,
  input  logic              vin2,
  input  logic              rdy,
  output logic [DATA_W-1:0] dout,
  output logic              vout,
  output logic              ovf,
  output logic              lane_err
);

  import fir_pkg::*;

  localparam int TW = N_LANES * DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  lane_e         state;
  logic [TW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          all_valid;
  logic          mismatch;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          room;

  assign all_valid = vin0 & vin1 & vin2;
  assign mismatch  = (vin0 | vin1 | vin2) & ~all_valid;
  assign xfer      = vout & rdy;
  assign pop       = xfer & (state == LANE2);
  assign room      = (fifo_count != CW'(DEPTH));
  assign push      = all_valid & (room | pop);
  // vout comes straight from the registered occupancy.
  assign vout      = ~fifo_empty;

  triplet_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({din0, din1, din2}),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Lane sequencer: moves one lane per completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LANE0;
    end else if (xfer) begin
      state <= next_lane(state);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      lane_err <= 1'b0;
    end else begin
      if (all_valid && fifo_full && !pop) begin
        ovf <= 1'b1;
      end
      if (mismatch) begin
        lane_err <= 1'b1;
      end
    end
  end

  // Output lane select from the registered head; zero while nothing is held.
  always_comb begin
    dout = '0;
    if (vout) begin
      case (state)
        LANE0:   dout = head[TW-1 -: DATA_W];
        LANE1:   dout = head[TW-DATA_W-1 -: DATA_W];
        LANE2:   dout = head[DATA_W-1:0];
        default: dout = '0;
      endcase
    end else begin
      dout = '0;
    end
  end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Self-checking bench for fir_out_serializer: a reference model counts
// pending samples, accepted triplets go to a scoreboard queue, and a
// monitor pops and compares on every transfer.
module tb_fir_out_serializer;

  localparam int DW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0, din2 = '0;
  logic          vin0 = 1'b0, vin1 = 1'b0, vin2 = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] dout;
  logic          vout, ovf, lane_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [$];
  int            pending = 0;
  logic          ovf_m = 1'b0;
  logic          lerr_m = 1'b0;

  fir_out_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .din0(din0), .din1(din1), .din2(din2),
    .vin0(vin0), .vin1(vin1), .vin2(vin2),
    .rdy(rdy), .dout(dout), .vout(vout), .ovf(ovf), .lane_err(lane_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending = samples accepted but not yet transferred.
  // Triplets held = ceil(pending/3); the last lane of the head is being
  // offered when pending mod 3 == 1.
  logic m_xfer, m_pop, m_allv, m_mism, m_accept;
  int   m_held;
  always_comb begin
    m_xfer   = (pending > 0) && rdy;
    m_pop    = m_xfer && (pending % 3 == 1);
    m_held   = (pending + 2) / 3;
    m_allv   = vin0 && vin1 && vin2;
    m_mism   = (vin0 || vin1 || vin2) && !m_allv;
    m_accept = m_allv && ((m_held < DEPTH) || m_pop);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 0;
      ovf_m   <= 1'b0;
      lerr_m  <= 1'b0;
      exp_q.delete();
    end else begin
      pending <= pending - (m_xfer ? 1 : 0) + (m_accept ? 3 : 0);
      if (m_accept) begin
        exp_q.push_back(din0);
        exp_q.push_back(din1);
        exp_q.push_back(din2);
      end
      if (m_allv && !m_accept) ovf_m <= 1'b1;
      if (m_mism) lerr_m <= 1'b1;
    end
  end

  // Monitor: mid-cycle sampling of outputs against the scoreboard.
  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("vout", int'(vout), int'(exp_q.size() != 0));
      chk("ovf", int'(ovf), int'(ovf_m));
      chk("lane_err", int'(lane_err), int'(lerr_m));
      if (vout && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", int'(dout), -1);
        end else begin
          chk("dout", int'(dout), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive(input logic [2:0] v, input int d0, input int d1,
                       input int d2, input logic r);
    @(posedge clk);
    #2;
    {vin0, vin1, vin2} = v;
    din0 = DW'(d0);
    din1 = DW'(d1);
    din2 = DW'(d2);
    rdy  = r;
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 0, 0, 0, r);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_vout", int'(vout), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_lane_err", int'(lane_err), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("por_vout", int'(vout), 0);
    chk("por_dout", int'(dout), 0);
    chk("por_flags", int'({ovf, lane_err}), 0);
    #1;
    rst_n = 1'b1;

    // Single triplet, rdy held high
    drive(3'b111, 12'h001, 12'h002, 12'h003, 1'b1);
    idle(1'b1, 6);

    // Ramp 0..89, one triplet every third cycle
    for (int t = 0; t < 30; t++) begin
      drive(3'b111, 3 * t, 3 * t + 1, 3 * t + 2, 1'b1);
      idle(1'b1, 2);
    end
    idle(1'b1, 6);
    chk("ramp_ovf", int'(ovf), 0);

    // Lane mismatch then valid traffic
    drive(3'b101, 12'h111, 12'h222, 12'h333, 1'b1);
    idle(1'b1, 2);
    chk("mismatch_no_out", int'(vout), 0);
    drive(3'b111, 12'h0A1, 12'h0A2, 12'h0A3, 1'b1);
    drive(3'b111, 12'h0B1, 12'h0B2, 12'h0B3, 1'b1);
    idle(1'b1, 8);
    chk("lane_err_sticky", int'(lane_err), 1);

    // Overflow: five triplets into a four-deep FIFO with rdy low
    pulse_reset();
    for (int t = 0; t < 5; t++) drive(3'b111, 16 * t + 1, 16 * t + 2, 16 * t + 3, 1'b0);
    idle(1'b0, 1);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(u_dut.u_fifo.count), DEPTH);
    idle(1'b1, 14);
    chk("ovf_drained", int'(exp_q.size()), 0);

    // Full FIFO: LANE2 transfer and a new triplet in the same cycle
    pulse_reset();
    for (int t = 0; t < 4; t++) drive(3'b111, 32 * t + 4, 32 * t + 5, 32 * t + 6, 1'b0);
    idle(1'b1, 2);
    drive(3'b111, 12'h1C1, 12'h1C2, 12'h1C3, 1'b1);
    drive(3'b000, 0, 0, 0, 1'b0);
    chk("full_pop_count", int'(u_dut.u_fifo.count), DEPTH);
    chk("full_pop_ovf", int'(ovf), 0);
    idle(1'b1, 16);

    // Reset while din1 of a buffered triplet is on dout
    drive(3'b111, 12'h010, 12'h020, 12'h030, 1'b1);
    drive(3'b000, 0, 0, 0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_dout", int'(dout), 12'h020);
    pulse_reset();
    drive(3'b111, 12'h3FF, 12'h200, 12'h000, 1'b1);
    drive(3'b000, 0, 0, 0, 1'b1);
    @(negedge clk);
    chk("post_reset_first", int'(dout), 12'h3FF);
    idle(1'b1, 6);

    // Randomized traffic with back-pressure and occasional lane errors
    for (int c = 0; c < 400; c++) begin
      int sel;
      logic [2:0] v;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) v = 3'b111;
      else if (sel == 4) v = 3'($urandom_range(1, 6));
      else v = 3'b000;
      drive(v, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 1023)), ($urandom_range(0, 3) != 0));
    end
    idle(1'b1, 60);
    chk("final_drain", int'(exp_q.size()), 0);
    chk("final_vout", int'(vout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
FIR_OUT_SERIALIZER -- requirements
Module: fir_out_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 10, sample width matching the FIR output lanes.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO capacity in triplets; power of two, at least 2.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports din0/din1/din2  in  DATA_W  filter lane outputs (dout0..2 of the unfolded FIR); lane 0 is the oldest sample.
REQ-006 SHALL have ports vin0/vin1/vin2  in  1  per-lane valid (vout0..2 of the unfolded FIR).
REQ-007 SHALL have port rdy  in  1  downstream ready.
REQ-008 SHALL have port dout  out  DATA_W  serialized sample.
REQ-009 SHALL have port vout  out  1  dout valid.
REQ-010 SHALL have port ovf  out  1  sticky overflow flag.
REQ-011 SHALL have port lane_err  out  1  sticky lane-mismatch flag.

Function
REQ-012 SHALL accept a triplet in a cycle where vin0, vin1 and vin2 are all 1, writing {din0,din1,din2} into the FIFO tail.
REQ-013 SHALL treat any cycle with vin0..2 not all equal as a lane error: set lane_err, discard the triplet, leave the FIFO unchanged.
REQ-014 SHALL emit the samples of each triplet in the order din0, din1, din2, one sample per transfer.
REQ-015 SHALL define a transfer as a cycle where vout=1 and rdy=1; dout and vout SHALL hold stable while vout=1 and rdy=0.
REQ-016 SHALL sequence lanes with a 3-state machine LANE0 -> LANE1 -> LANE2 -> LANE0; it advances only on a transfer, and the LANE2 transfer pops the FIFO head.
REQ-017 SHALL drive vout=1 whenever the FIFO holds at least one triplet.
REQ-018 SHALL drive dout as the head-entry lane selected by the state, with no combinational path from din*, vin* or rdy to dout or vout.
REQ-019 SHALL give a latency, with the FIFO empty, of: triplet accepted at edge k, so vout=1 and dout=din0 in the cycle after edge k.
REQ-020 SHALL sustain one sample per cycle while rdy=1; a triplet every 3 cycles is lossless indefinitely.
REQ-021 SHALL handle a full FIFO as follows: if the FIFO is full and a valid triplet arrives, accept it only if a LANE2 transfer pops the head in the same cycle; otherwise drop it and set ovf.
REQ-022 SHALL, on a simultaneous write and pop at any fill level, keep the count unchanged and update both pointers.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH; the count SHALL be DEPTH-range +1 bits wide, so full and empty are unambiguous.
REQ-024 SHALL clear ovf and lane_err only on reset.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force dout=0, vout=0, ovf=0, lane_err=0, state LANE0, pointers 0 and count 0.
REQ-026 SHALL, on reset asserted mid-triplet or mid-burst, discard all buffered data; the first sample after release is din0 of the next accepted triplet.
REQ-027 SHALL leave FIFO storage contents unreset; they are never visible while the count is 0.

Structure
REQ-028 SHALL take DATA_W, N_LANES=3 and the lane-state enumeration (LANE0/LANE1/LANE2) from the shared package fir_pkg.
REQ-029 SHALL implement triplet storage as one sub-module, triplet_fifo, with push/pop/full/empty/count and registered head output; lane sequencing and the flags SHALL live in the top level.

Verification
REQ-030 SHALL pass this scenario: one triplet (0x001, 0x002, 0x003) with rdy=1 -> vout high for exactly 3 cycles starting the cycle after acceptance; dout = 0x001, 0x002, 0x003; then vout=0.
REQ-031 SHALL pass this scenario: triplets every 3rd cycle for 30 triplets (ramp 0..89) with rdy=1 -> dout = 0..89 in order, ovf=0.
REQ-032 SHALL pass this scenario: rdy=0, push 5 triplets at DEPTH=4 -> 4 stored, ovf=1 after the 5th; rdy=1 -> 12 samples out, the 5th triplet is absent.
REQ-033 SHALL pass this scenario: FIFO full, the LANE2 transfer and a new triplet in the same cycle -> triplet accepted, ovf stays 0, count stays 4.
REQ-034 SHALL pass this scenario: vin = (1,0,1) for one cycle -> lane_err=1 and no sample emitted; later valid triplets are still serialized correctly.
REQ-035 SHALL pass this scenario: rst_n pulsed low while dout=din1 of a buffered triplet -> vout=0 immediately, flags 0; the next triplet (0x3FF, 0x200, 0x000) is emitted starting with 0x3FF.
